// File: rtl/descf_reader.sv
// descf_reader: Avalon-MM read master that walks a linked chain of 4-word descriptors and streams each one out
module descf_reader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_DESC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_ptr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_clken,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  output logic [15:0]       desc_ctrl,
  output logic              desc_last
);
  localparam int CW = $clog2(MAX_DESC + 1);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, PRESENT, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        k;
  logic [ADDR_W-1:0] ptr, nxt;
  logic [CW-1:0]     count;
  logic [31:0]       w0, w1, w2;
  logic              own, eoc, err, err_set, start_ok;

  // next-state decode; abort from any active state beats every other transition
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    start_ok = 1'b0;
    if (abort && state != IDLE) state_nx = IDLE;
    else
      case (state)
        IDLE: if (start && !abort) begin
          start_ok = 1'b1;
          err_set  = first_ptr[1:0] != 2'b00;
          state_nx = (first_ptr[1:0] != 2'b00) ? DONE : FETCH;
        end
        FETCH:   state_nx = (k == 3'd4) ? CHECK : FETCH;
        CHECK:   state_nx = own ? PRESENT : DONE;
        PRESENT: if (desc_ready) begin
          err_set  = !eoc && (nxt[1:0] != 2'b00 || count == CW'(MAX_DESC));
          state_nx = (eoc || err_set) ? DONE : FETCH;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  // fetch sequencing, chain pointer, descriptor count, sticky error and word capture
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      k     <= '0;
      ptr   <= '0;
      nxt   <= '0;
      count <= '0;
      err   <= 1'b0;
      w0    <= '0;
      w1    <= '0;
      w2    <= '0;
      own   <= 1'b0;
      eoc   <= 1'b0;
    end else begin
      k <= (state == FETCH && state_nx == FETCH) ? k + 3'd1 : 3'd0;
      if (start_ok) begin
        ptr   <= first_ptr;
        count <= '0;
      end else if (state == PRESENT && state_nx == FETCH) ptr <= nxt;
      if (state == CHECK && own) count <= count + CW'(1);
      err <= err_set | (err & ~start_ok);
      if (state == FETCH) begin
        if (k == 3'd1) w0 <= m_readdata[31:0];
        if (k == 3'd2) w1 <= m_readdata[31:0];
        if (k == 3'd3) w2 <= m_readdata[31:0];
        if (k == 3'd4) begin
          own <= m_readdata[31];
          eoc <= m_readdata[30];
          nxt <= m_readdata[ADDR_W-1:0];
        end
      end
    end

  assign busy         = state != IDLE;
  assign done         = state == DONE;
  assign error        = err;
  assign m_read       = state == FETCH && k != 3'd4;
  assign m_chipselect = m_read;
  assign m_clken      = 1'b1;
  assign m_address    = ptr + ADDR_W'(k[1:0]);
  assign desc_valid   = state == PRESENT;
  assign desc_src     = w0;
  assign desc_dst     = w1;
  assign desc_len     = w2[15:0];
  assign desc_ctrl    = w2[31:16];
  assign desc_last    = eoc;
endmodule

// File: tb/tb_descf_reader.sv
// tb_descf_reader: directed bench for descf_reader with a chain-walking reference model
module tb_descf_reader;
  localparam int MAXD = 4;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [15:0] ctrl;
    logic        last;
  } desc_t;

  logic        clk = 0, reset_n = 0, start = 0, abort = 0, desc_ready = 1;
  logic [7:0]  first_ptr = 0;
  logic        busy, done, error, m_chipselect, m_clken, m_read, desc_valid, desc_last;
  logic [7:0]  m_address;
  logic [31:0] m_readdata, desc_src, desc_dst;
  logic [15:0] desc_len, desc_ctrl;
  logic [31:0] mem [256];

  int tests = 0, fails = 0, cyc = 0, acc_cnt = 0, done_cnt = 0;
  desc_t exp_desc[$];
  logic [7:0] exp_addr[$];
  int acc_cyc[$];
  bit exp_done = 0, exp_err = 0;

  descf_reader #(.ADDR_W(8), .DATA_W(32), .MAX_DESC(MAXD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .first_ptr(first_ptr),
    .busy(busy), .done(done), .error(error), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_clken(m_clken), .m_read(m_read), .m_readdata(m_readdata),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src), .desc_dst(desc_dst),
    .desc_len(desc_len), .desc_ctrl(desc_ctrl), .desc_last(desc_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_read) m_readdata <= mem[m_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put(input logic [7:0] p, input logic [31:0] a, b, c, d);
    mem[p] = a;
    mem[p + 8'd1] = b;
    mem[p + 8'd2] = c;
    mem[p + 8'd3] = d;
  endtask

  task automatic plan(input logic [7:0] p0);
    logic [7:0] p;
    logic [31:0] w3;
    desc_t d;
    int n;
    p = p0;
    n = 0;
    exp_addr.delete();
    exp_desc.delete();
    exp_done = 1;
    exp_err = 0;
    if (p[1:0] != 2'b00) begin
      exp_err = 1;
      return;
    end
    while (1) begin
      for (int i = 0; i < 4; i++) exp_addr.push_back(p + 8'(i));
      w3 = mem[p + 8'd3];
      if (!w3[31]) break;
      n++;
      d.src = mem[p];
      d.dst = mem[p + 8'd1];
      d.len = mem[p + 8'd2][15:0];
      d.ctrl = mem[p + 8'd2][31:16];
      d.last = w3[30];
      exp_desc.push_back(d);
      if (w3[30]) break;
      if (w3[1:0] != 2'b00 || n == MAXD) begin
        exp_err = 1;
        break;
      end
      p = w3[7:0];
    end
  endtask

  task automatic clear_model();
    exp_addr.delete();
    exp_desc.delete();
    exp_done = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [7:0] p);
    @(posedge clk);
    #1;
    first_ptr = p;
    start = 1;
    plan(p);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_for(input string name, input bit want_done, input int maxc);
    int i;
    i = 0;
    while (!(want_done ? done : desc_valid) && i < maxc) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(name, want_done ? done : desc_valid, 1);
  endtask

  // per-cycle comparison of the RAM port, descriptor stream and completion against the model
  always @(negedge clk) if (reset_n) begin
    chk("m_clken", m_clken, 1);
    chk("m_chipselect", m_chipselect, m_read);
    if (m_read) begin
      chk("read_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) chk("m_address", m_address, exp_addr.pop_front());
    end
    if (desc_valid) begin
      chk("valid_expected", exp_desc.size() != 0, 1);
      if (exp_desc.size() != 0) begin
        chk("desc_src", desc_src, exp_desc[0].src);
        chk("desc_dst", desc_dst, exp_desc[0].dst);
        chk("desc_len", desc_len, exp_desc[0].len);
        chk("desc_ctrl", desc_ctrl, exp_desc[0].ctrl);
        chk("desc_last", desc_last, exp_desc[0].last);
        if (desc_ready && !abort) begin
          void'(exp_desc.pop_front());
          acc_cnt++;
          acc_cyc.push_back(cyc);
        end
      end
    end
    if (done) begin
      chk("done_expected", exp_done, 1);
      chk("error_at_done", error, exp_err);
      chk("reads_left", exp_addr.size(), 0);
      chk("descs_left", exp_desc.size(), 0);
      exp_done = 0;
      done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, n0, gap;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    put(8'h10, 32'hA, 32'hB, 32'h0003_0040, 32'hC000_0000);
    put(8'h00, 32'h100, 32'h200, 32'h0001_0010, 32'h8000_0020);
    put(8'h20, 32'h300, 32'h400, 32'h0002_0020, 32'h8000_0040);
    put(8'h40, 32'h500, 32'h600, 32'h0003_0030, 32'hC000_0000);
    put(8'h04, 32'h1234, 32'h5678, 32'h9, 32'h0000_0010);
    put(8'h08, 32'h11, 32'h22, 32'h0005_0008, 32'h8000_0008);
    put(8'hFC, 32'hFC0, 32'hFC1, 32'h0007_0077, 32'hC000_0000);

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_cs", m_chipselect, 0);
    chk("rst_m_clken", m_clken, 1);
    chk("rst_m_address", m_address, 0);
    chk("rst_valid", desc_valid, 0);
    chk("rst_fields", {desc_src, desc_dst, desc_len, desc_ctrl, desc_last}, 0);
    #10 reset_n = 1;
    step(2);

    // single descriptor with exact latency
    go(8'h10);
    chk("t1_busy", busy, 1);
    chk("t1_read0", m_read, 1);
    chk("t1_addr0", m_address, 8'h10);
    step(5);
    chk("t1_no_valid_e5", desc_valid, 0);
    step(1);
    chk("t1_valid_e6", desc_valid, 1);
    chk("t1_src", desc_src, 32'hA);
    chk("t1_dst", desc_dst, 32'hB);
    chk("t1_len", desc_len, 16'h40);
    chk("t1_ctrl", desc_ctrl, 16'h3);
    chk("t1_last", desc_last, 1);
    step(1);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_valid_low", desc_valid, 0);
    step(1);
    chk("t1_idle", busy, 0);
    chk("t1_done_low", done, 0);

    // three-descriptor chain with a stall on the second
    desc_ready = 0;
    a0 = acc_cnt;
    d0 = done_cnt;
    go(8'h00);
    wait_for("t2_valid1", 0, 20);
    desc_ready = 1;
    step(1);
    desc_ready = 0;
    wait_for("t2_valid2", 0, 20);
    step(3);
    chk("t2_stall_valid", desc_valid, 1);
    chk("t2_stall_src", desc_src, 32'h300);
    desc_ready = 1;
    wait_for("t2_done", 1, 30);
    step(3);
    chk("t2_count", acc_cnt - a0, 3);
    chk("t2_single_done", done_cnt - d0, 1);

    // unowned descriptor ends the walk quietly
    a0 = acc_cnt;
    go(8'h04);
    step(5);
    chk("t3_no_done_e5", done, 0);
    step(1);
    chk("t3_done_e6", done, 1);
    chk("t3_error", error, 0);
    chk("t3_no_valid", desc_valid, 0);
    step(1);
    chk("t3_idle", busy, 0);
    chk("t3_no_desc", acc_cnt - a0, 0);

    // misaligned first pointer
    go(8'h05);
    chk("t4_done", done, 1);
    chk("t4_error", error, 1);
    chk("t4_no_read", m_read, 0);
    step(1);
    chk("t4_idle", busy, 0);
    chk("t4_error_sticky", error, 1);

    // self-loop hits the chain-length guard
    a0 = acc_cnt;
    n0 = acc_cyc.size();
    go(8'h08);
    chk("t5_error_cleared", error, 0);
    wait_for("t5_done", 1, 100);
    chk("t5_error", error, 1);
    step(1);
    chk("t5_count", acc_cnt - a0, 4);
    gap = (acc_cyc.size() > n0 + 1) ? acc_cyc[n0+1] - acc_cyc[n0] : -1;
    chk("t5_period", gap, 7);

    // abort during fetch
    go(8'h10);
    step(1);
    abort = 1;
    step(1);
    abort = 0;
    clear_model();
    chk("t6a_busy", busy, 0);
    chk("t6a_read", m_read, 0);
    chk("t6a_valid", desc_valid, 0);
    chk("t6a_done", done, 0);
    chk("t6a_error", error, 0);
    d0 = done_cnt;
    step(4);
    chk("t6a_no_done", done_cnt - d0, 0);

    // abort during present, beating desc_ready
    desc_ready = 0;
    go(8'h10);
    wait_for("t6b_valid", 0, 20);
    abort = 1;
    desc_ready = 1;
    a0 = acc_cnt;
    step(1);
    abort = 0;
    clear_model();
    chk("t6b_valid", desc_valid, 0);
    chk("t6b_busy", busy, 0);
    chk("t6b_done", done, 0);
    chk("t6b_no_accept", acc_cnt - a0, 0);

    // start and abort together in idle
    step(1);
    first_ptr = 8'h10;
    start = 1;
    abort = 1;
    step(1);
    start = 0;
    abort = 0;
    chk("t6c_busy", busy, 0);
    chk("t6c_read", m_read, 0);
    step(2);

    // address wrap at the top of the RAM
    go(8'hFC);
    chk("t6d_addr0", m_address, 8'hFC);
    step(3);
    chk("t6d_addr3", m_address, 8'hFF);
    wait_for("t6d_done", 1, 20);
    step(2);

    // asynchronous reset mid-operation
    go(8'h10);
    step(2);
    #2 reset_n = 0;
    clear_model();
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_read", m_read, 0);
    chk("t7_addr", m_address, 0);
    chk("t7_fields", {desc_src, desc_dst, desc_len, desc_ctrl, desc_last}, 0);
    chk("t7_error", error, 0);
    step(1);
    reset_n = 1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
